// File: rtl/lsu_stage.sv
// RV32 load/store stage: one memory transaction per start over a req/ready handshake,
// with store lane alignment, byte-enable generation and load sign/zero extension.
module lsu_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    state_t                state, state_nxt;
    logic                  store_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic                  accept, illegal, misaligned;
    logic [3:0]            be_c;
    logic [DATA_WIDTH-1:0] wdata_c;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_fmt;

    assign accept = (state == IDLE) && en && start;

    // funct3[1:0] encodes access size (00 B, 01 H, 10 W); funct3[2] selects unsigned loads.
    assign illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        be_c    = 4'b1111;
        wdata_c = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_fmt = mem_rdata;
        case (f3_q[1:0])
            2'b00:   load_fmt = {{(DATA_WIDTH-8){~f3_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_fmt = {{(DATA_WIDTH-16){~f3_q[2] & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (illegal || misaligned) ? ERR : REQ;
            REQ:     if (mem_ready) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            store_q   <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                store_q   <= is_store;
                f3_q      <= funct3;
                off_q     <= addr[1:0];
                mem_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
                mem_be    <= be_c;
                mem_wdata <= wdata_c;
            end
            if ((state == REQ) && mem_ready && !store_q) rdata <= load_fmt;
        end
    end

    // Decoded straight from state so an asynchronous reset drops the request at once.
    assign mem_req = (state == REQ);
    assign mem_we  = mem_req && store_q;
    assign busy    = (state != IDLE);
    assign done    = (state == RESP) || (state == ERR);
    assign fault   = (state == ERR);

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage: loads, stores, wait states, faults and mid-transaction reset.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    lsu_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns #1 after the accepting edge.
    task automatic go(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Zero-wait load: request visible in cycle N+1, completion in N+2.
    task automatic zero_wait_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [3:0] be, input logic [31:0] exp_rdata);
        go(1'b0, f3, a, 32'h0);
        check({tag, " req"}, {31'h0, mem_req}, 32'h1);
        check({tag, " be"}, {28'h0, mem_be}, {28'h0, be});
        tick();
        check({tag, " done"}, {30'h0, done, fault}, 32'h2);
        check({tag, " rdata"}, rdata, exp_rdata);
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h0;
        #2;
        check("reset ctl", {27'h0, busy, done, fault, mem_req, mem_we}, 32'h0);
        check("reset addr", mem_addr, 32'h0);
        check("reset be", {28'h0, mem_be}, 32'h0);
        check("reset wdata", mem_wdata, 32'h0);
        check("reset rdata", rdata, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // en low: start must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("en low busy", {31'h0, busy}, 32'h0);
        en = 1'b1;

        // LW zero-wait
        mem_rdata = 32'hDEADBEEF;
        go(1'b0, 3'b010, 32'h100, 32'h0);
        check("lw req", {30'h0, mem_req, mem_we}, 32'h2);
        check("lw addr", mem_addr, 32'h100);
        check("lw be", {28'h0, mem_be}, 32'hF);
        check("lw done early", {31'h0, done}, 32'h0);
        tick();
        check("lw done", {29'h0, done, fault, mem_req}, 32'h4);
        check("lw rdata", rdata, 32'hDEADBEEF);
        tick();
        check("lw idle", {30'h0, busy, done}, 32'h0);

        // Sub-word loads
        mem_rdata = 32'h80FF_0000;
        zero_wait_load("lb", 3'b000, 32'h103, 4'b1000, 32'hFFFFFF80);
        zero_wait_load("lbu", 3'b100, 32'h103, 4'b1000, 32'h00000080);
        zero_wait_load("lhu", 3'b101, 32'h102, 4'b1100, 32'h000080FF);
        zero_wait_load("lh", 3'b001, 32'h102, 4'b1100, 32'hFFFF80FF);
        zero_wait_load("lbu0", 3'b100, 32'h100, 4'b0001, 32'h00000000);

        // Stores leave rdata untouched
        go(1'b1, 3'b000, 32'h201, 32'h12345678);
        check("sb addr", mem_addr, 32'h200);
        check("sb we", {30'h0, mem_req, mem_we}, 32'h3);
        check("sb be", {28'h0, mem_be}, 32'h2);
        check("sb wdata", mem_wdata, 32'h78787878);
        tick();
        check("sb done", {30'h0, done, fault}, 32'h2);
        check("sb rdata kept", rdata, 32'h0);
        tick();
        go(1'b1, 3'b001, 32'h202, 32'h12345678);
        check("sh be", {28'h0, mem_be}, 32'hC);
        check("sh wdata", mem_wdata, 32'h56785678);
        tick(); tick();
        go(1'b1, 3'b010, 32'h204, 32'h12345678);
        check("sw be", {28'h0, mem_be}, 32'hF);
        check("sw wdata", mem_wdata, 32'h12345678);
        check("sw addr", mem_addr, 32'h204);
        tick(); tick();

        // Wait states plus a start while busy
        mem_ready = 1'b0;
        mem_rdata = 32'hCAFEF00D;
        go(1'b0, 3'b010, 32'h300, 32'h0);
        start = 1'b1; is_store = 1'b1; addr = 32'h400;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("wait req c%0d", c), {29'h0, mem_req, mem_we, done}, 32'h4);
            check($sformatf("wait addr c%0d", c), mem_addr, 32'h300);
            if (c == 1) begin
                start = 1'b0; is_store = 1'b0;
            end
            if (c == 4) mem_ready = 1'b1;
            tick();
        end
        check("wait done", {30'h0, done, fault}, 32'h2);
        check("wait rdata", rdata, 32'hCAFEF00D);
        tick();
        check("wait single done", {30'h0, busy, done}, 32'h0);
        tick();
        check("ignored start", {31'h0, mem_req}, 32'h0);

        // Fault cases: done+fault one cycle after start, no request
        go(1'b0, 3'b010, 32'h102, 32'h0);
        check("lw mis", {29'h0, done, fault, mem_req}, 32'h6);
        check("lw mis rdata", rdata, 32'hCAFEF00D);
        tick();
        check("lw mis end", {30'h0, busy, done}, 32'h0);
        go(1'b1, 3'b001, 32'h101, 32'h0);
        check("sh mis", {29'h0, done, fault, mem_req}, 32'h6);
        tick();
        go(1'b0, 3'b011, 32'h100, 32'h0);
        check("f3 011", {29'h0, done, fault, mem_req}, 32'h6);
        check("f3 011 rdata", rdata, 32'hCAFEF00D);
        tick();
        go(1'b1, 3'b100, 32'h100, 32'h0);
        check("sbu illegal", {29'h0, done, fault, mem_req}, 32'h6);
        tick();

        // Reset while waiting in REQ
        mem_ready = 1'b0;
        go(1'b0, 3'b010, 32'h500, 32'h0);
        check("rst pre req", {31'h0, mem_req}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst drops req", {30'h0, mem_req, busy}, 32'h0);
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("rst no done", {30'h0, done, busy}, 32'h0);
        check("rst rdata", rdata, 32'h0);
        mem_rdata = 32'h11223344;
        go(1'b0, 3'b010, 32'h500, 32'h0);
        check("post rst req", mem_addr, 32'h500);
        tick();
        check("post rst done", {30'h0, done, fault}, 32'h2);
        check("post rst rdata", rdata, 32'h11223344);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store stage directly downstream of the ALU in the RV32 datapath.
- Takes the ALU result as the effective address plus store data and funct3, and runs one memory transaction over a req/ready handshake.
- Aligns store data, generates byte enables, and extracts plus sign/zero-extends load data for writeback.
- Multi-cycle; pipeline control stalls on busy.

Parameters:
- DATA_WIDTH, 32, width of address, store data, load result and memory data bus; byte-enable logic assumes 32.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  stage enable; start ignored when low
- start  input  1  request a transaction (sampled in IDLE only)
- is_store  input  1  1 = store, 0 = load
- funct3  input  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
- addr  input  DATA_WIDTH  effective address (ALU y)
- wdata  input  DATA_WIDTH  store data (rs2)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion pulse
- fault  output  1  valid with done: misaligned or illegal funct3
- rdata  output  DATA_WIDTH  extended load result, held until next load completes
- mem_req  output  1  memory request
- mem_we  output  1  write strobe, valid with mem_req
- mem_addr  output  DATA_WIDTH  word address, addr[1:0] forced to 00
- mem_be  output  4  byte enables
- mem_wdata  output  DATA_WIDTH  lane-aligned store data
- mem_ready  input  1  memory accepts/completes request this cycle
- mem_rdata  input  DATA_WIDTH  read data, valid when mem_ready and !mem_we

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, fault, mem_req, mem_we=0. mem_addr, mem_be, mem_wdata, rdata=0.
  - Mid-transaction reset drops mem_req immediately; the transaction is abandoned and done is never pulsed.
- States: IDLE, REQ, RESP, ERR.
- IDLE, en&&start:
  - Latch is_store, funct3, addr[1:0], wdata.
  - Illegal combination (funct3 011/110/111, or store with funct3[2]=1) -> ERR.
  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=00) -> ERR.
  - Otherwise -> REQ.
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_be, mem_wdata drive latched values and stay stable until mem_ready.
  - Stay in REQ while mem_ready=0.
  - On mem_ready=1: if load, capture formatted mem_rdata into rdata. Next state RESP.
- RESP: done=1, fault=0, mem_req=0 -> IDLE.
- ERR: done=1, fault=1, no memory request, rdata unchanged -> IDLE.
- Latency: zero-wait memory gives start accepted at edge N, mem_req high cycle N+1, done high cycle N+2. Each wait cycle adds one.
- Back-to-back: a new start is sampled in the cycle after done, i.e. in IDLE. start during busy is ignored; there is no queue.
- Byte enables, k = addr[1:0]:
  - B: 1<<k
  - H: 0011 (k=0) or 1100 (k=2)
  - W: 1111
- Store data placement: B replicates wdata[7:0] to all 4 lanes; H replicates wdata[15:0] to both halves; W passes through.
- Load extraction:
  - B/BU select byte k and sign/zero-extend to 32.
  - H/HU select half k[1] and sign/zero-extend to 32.
  - W passes through.
- mem_ready outside REQ is ignored.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, zero-wait -> mem_addr=0x100, mem_be=1111, done at start+2, rdata=0xDEADBEEF, fault=0.
- LB addr=0x103, mem_rdata=0x80FF_0000 -> mem_be=1000, rdata=0xFFFFFF80. LBU same -> rdata=0x00000080. LHU addr=0x102 -> rdata=0x000080FF.
- SB addr=0x201, wdata=0x12345678 -> mem_addr=0x200, mem_we=1, mem_be=0010, mem_wdata=0x78787878. SH addr=0x202 -> mem_be=1100, mem_wdata=0x56785678.
- mem_ready held low 3 cycles -> mem_req and outputs stable for 4 cycles, done exactly once at start+5. A start pulse while busy is ignored.
- LW addr=0x102, then SH addr=0x101, then funct3=011 -> each gives done=1, fault=1 one cycle after start, mem_req never asserted, rdata unchanged.
- rst pulsed high while in REQ (mem_ready=0) -> mem_req=0 in the same cycle, busy=0, no done pulse. Next LW completes normally.
